// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-port arbiter: FSM states, read-owner tags and memory size codes.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    LSU_PRI   = 2'd0,
    PROG_PRI  = 2'd1,
    PROG_LOCK = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LSU  = 2'd1,
    OWN_PROG = 2'd2
  } arb_owner_t;

  localparam logic [1:0] MEM_SZ_BYTE = 2'd0;
  localparam logic [1:0] MEM_SZ_HALF = 2'd1;
  localparam logic [1:0] MEM_SZ_WORD = 2'd2;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// One requester's view of the shared memory data port: request fields out, grant and read data back.
interface dmem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [1:0]    size;
  logic          sign;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;

  modport master (
    output req, we, addr, wdata, size, sign,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, size, sign,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_port_arbiter_age_ctr.sv
// Saturating count of cycles PROG has been refused; hit_max flags the last tolerated refusal.
module arb_age_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              hit_max
);

  localparam logic [WAIT_W-1:0] MAX_CNT  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != MAX_CNT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign wait_cnt = cnt_reg;
  assign hit_max  = (cnt_reg >= LAST_CNT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares memory data port 2 between the LSU and the programmer/debug loader,
// with LSU default priority, PROG aging and PROG burst locking.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int AW       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_port_arbiter_if.slave  lsu,
  dmem_port_arbiter_if.slave  prog,
  input  logic                prog_lock,
  output logic [AW-1:0]       mem_addr2,
  output logic [31:0]         mem_din2,
  output logic                mem_read2,
  output logic                mem_write2,
  output logic [1:0]          mem_size,
  output logic                mem_sign,
  input  logic [31:0]         mem_dout2
);

  arb_state_t        state_reg, state_next;
  arb_owner_t        owner_reg, owner_next;
  logic              lsu_gnt, prog_gnt;
  logic              hit_max;
  logic [WAIT_W-1:0] wait_cnt;

  arb_age_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (prog.req && !prog_gnt),
    .clr      (prog_gnt || !prog.req),
    .wait_cnt (wait_cnt),
    .hit_max  (hit_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LSU_PRI;
      owner_reg <= OWN_NONE;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lsu_gnt    = 1'b0;
    prog_gnt   = 1'b0;
    case (state_reg)
      LSU_PRI: begin
        lsu_gnt  = lsu.req;
        prog_gnt = prog.req && !lsu.req;
        if (prog_gnt && prog_lock) begin
          state_next = PROG_LOCK;
        end else if (prog.req && !prog_gnt && hit_max) begin
          state_next = PROG_PRI;
        end
      end
      PROG_PRI: begin
        prog_gnt   = prog.req;
        lsu_gnt    = lsu.req && !prog.req;
        state_next = (prog.req && prog_lock) ? PROG_LOCK : LSU_PRI;
      end
      PROG_LOCK: begin
        // The LSU is shut out for the whole burst; the unlocking cycle is still PROG's.
        prog_gnt = prog.req;
        if (!prog_lock) begin
          state_next = LSU_PRI;
        end
      end
      default: begin
        state_next = LSU_PRI;
      end
    endcase
  end

  always_comb begin
    mem_addr2  = '0;
    mem_din2   = '0;
    mem_read2  = 1'b0;
    mem_write2 = 1'b0;
    mem_size   = '0;
    mem_sign   = 1'b0;
    owner_next = OWN_NONE;
    if (lsu_gnt) begin
      mem_addr2  = lsu.addr;
      mem_din2   = lsu.wdata;
      mem_read2  = !lsu.we;
      mem_write2 = lsu.we;
      mem_size   = lsu.size;
      mem_sign   = lsu.sign;
      owner_next = lsu.we ? OWN_NONE : OWN_LSU;
    end else if (prog_gnt) begin
      mem_addr2  = prog.addr;
      mem_din2   = prog.wdata;
      mem_read2  = !prog.we;
      mem_write2 = prog.we;
      mem_size   = prog.size;
      mem_sign   = prog.sign;
      owner_next = prog.we ? OWN_NONE : OWN_PROG;
    end
  end

  assign lsu.gnt     = lsu_gnt;
  assign prog.gnt    = prog_gnt;
  assign lsu.rvalid  = (owner_reg == OWN_LSU);
  assign prog.rvalid = (owner_reg == OWN_PROG);
  assign lsu.rdata   = (owner_reg == OWN_LSU)  ? mem_dout2 : 32'd0;
  assign prog.rdata  = (owner_reg == OWN_PROG) ? mem_dout2 : 32'd0;

endmodule
